sync_arb: RTL and testbench
===========================

SYNC_ARB -- requirements
Module: sync_arb

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter TMO, default 200, meaning the BUSY timeout in clock cycles (1..255).
REQ-003 Port list (name  direction  width  meaning):
- clock  input  1  the single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  request per requester; asynchronous to clock, 4-phase level protocol.
- done  input  1  resource completion, synchronous to clock.
- gnt  output  N  one-hot grant, registered.
- gnt_id  output  3  index of the granted requester, valid while busy=1.
- start  output  1  one-cycle pulse that launches the resource.
- busy  output  1  resource owned by a requester.
- timeout  output  1  one-cycle pulse when BUSY exceeds TMO.
REQ-004 The reset SHALL be asynchronous and active-high, and clock SHALL be the only clock.

Function
REQ-005 Each req[i] SHALL pass through a two-flop synchronizer; the second-flop output is req_s[i], and no logic SHALL use raw req.
REQ-006 The state machine SHALL have exactly four states: IDLE, START, BUSY and RELEASE.
REQ-007 IDLE: if any req_s=1, the block SHALL select a winner, load gnt/gnt_id and go to START; otherwise it stays in IDLE.
REQ-008 Winner selection SHALL be round-robin: the first i with req_s[i]=1, searching ptr, ptr+1, ... modulo N.
REQ-009 START SHALL last exactly one cycle with start=1, then go to BUSY.
REQ-010 BUSY: done=1 SHALL go to RELEASE.
REQ-011 BUSY: if the cycle counter reaches TMO with done=0, the block SHALL pulse timeout for one cycle and go to RELEASE.
REQ-012 If done=1 in the same cycle the counter reaches TMO, done SHALL win and timeout SHALL stay 0.
REQ-013 The BUSY counter SHALL be 8 bits, clear on entry to BUSY, and saturate without wrap.
REQ-014 RELEASE SHALL hold gnt until req_s[gnt_id]=0.
REQ-015 On leaving RELEASE, the block SHALL clear gnt, set ptr=(gnt_id+1) mod N, and go to IDLE.
REQ-016 done SHALL be ignored in IDLE, START and RELEASE.
REQ-017 Requests that rise or fall while not in IDLE SHALL NOT change gnt or gnt_id.
REQ-018 busy SHALL be 1 in START, BUSY and RELEASE, and 0 in IDLE.
REQ-019 gnt SHALL be all-zero in IDLE, and exactly one bit SHALL be set elsewhere.
REQ-020 gnt_id SHALL be 0 whenever busy=0.
REQ-021 Latency: a req rising before clock edge k SHALL produce gnt=1 after edge k+2 and start=1 during the cycle after edge k+2, provided the block is idle at k+2.
REQ-022 No requester SHALL be granted twice while another requester holds req_s=1 continuously (starvation-free).

Reset
REQ-023 While reset=1, the block SHALL force state=IDLE, ptr=0, all synchronizer flops=0, gnt=0, gnt_id=0, start=0, busy=0, timeout=0 immediately, without waiting for a clock edge.
REQ-024 Reset asserted mid-transaction SHALL abort the transaction without a done/timeout pulse.
REQ-025 After reset releases, the block SHALL restart from IDLE, and a still-high req SHALL be granted again after the two-flop delay.

Verification
REQ-026 Single request: req=4'b0100 held, done pulsed 5 cycles after start, req dropped -> gnt=4'b0100, gnt_id=2, one start pulse, busy=1 from START through RELEASE, then ptr=3.
REQ-027 Contention: req=4'b1111 held, each done prompt and each granted req dropped then re-raised -> grant order 0,1,2,3,0.
REQ-028 Timeout: req=4'b0001, done never asserted -> timeout pulses exactly TMO cycles after BUSY entry, state goes to RELEASE, gnt held until req drops.
REQ-029 Simultaneous events: done=1 on the TMO cycle -> RELEASE entered and timeout=0.
REQ-030 Glitches: req pulses of 2-3 ns between clock edges (clock period 40 ns) -> no grant, or at most one complete clean transaction, never a multi-hot gnt.
REQ-031 Reset mid-BUSY: reset=1 for 10 ns -> all outputs 0 at once; after release, held req=4'b0010 is re-granted with gnt=4'b0010.

Source files
------------

// File: rtl/sync_arb.sv
// Round-robin arbiter granting one of N asynchronous requesters ownership of a shared resource.
// Requests are double-flopped; a four-state FSM runs the start/busy/release handshake with a BUSY timeout.
module sync_arb #(
    parameter int unsigned N   = 4,
    parameter int unsigned TMO = 200
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic [2:0]   gnt_id,
    output logic         start,
    output logic         busy,
    output logic         timeout
);

    localparam int unsigned IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [7:0]  TMO_LAST = 8'(TMO - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] req_m_q, req_s_q;
    logic [2:0]   ptr_q, ptr_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic [2:0]   gnt_id_q, gnt_id_d;
    logic         start_q, start_d;
    logic         busy_q, busy_d;
    logic         timeout_q, timeout_d;
    logic [7:0]   cnt_q, cnt_d;

    logic         found;
    logic [2:0]   win_id;
    int unsigned  idx;

    // Two-flop synchronizer; nothing downstream looks at raw req.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_m_q <= '0;
            req_s_q <= '0;
        end else begin
            req_m_q <= req;
            req_s_q <= req_m_q;
        end
    end

    // First active synchronized request at or after ptr, wrapping modulo N.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        idx    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr_q) + k) % N;
            if (!found && req_s_q[IW'(idx)]) begin
                found  = 1'b1;
                win_id = 3'(idx);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outputs are computed one cycle ahead so they line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        start_d   = 1'b0;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = START;
                    gnt_d    = N'(1) << win_id;
                    gnt_id_d = win_id;
                    start_d  = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                state_d = BUSY;
                cnt_d   = '0;
            end
            BUSY: begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                // done has priority over a timeout landing in the same cycle.
                if (done) begin
                    state_d = RELEASE;
                end else if (cnt_q >= TMO_LAST) begin
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                end
            end
            RELEASE: begin
                if (!req_s_q[IW'(gnt_id_q)]) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    busy_d   = 1'b0;
                    ptr_d    = 3'((32'(gnt_id_q) + 1) % N);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign start   = start_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_sync_arb.sv
// Directed bench for sync_arb: expected grant order is queued as requests are driven
// and checked when start is seen; timing-critical outputs are checked inline.
module tb_sync_arb;

    localparam int unsigned N   = 4;
    localparam int unsigned TMO = 12;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req   = '0;
    logic         done  = 1'b0;
    logic [N-1:0] gnt;
    logic [2:0]   gnt_id;
    logic         start;
    logic         busy;
    logic         timeout;

    int n_cmp = 0;
    int n_mis = 0;
    int exp_q[$];

    sync_arb #(.N(N), .TMO(TMO)) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .start   (start),
        .busy    (busy),
        .timeout (timeout)
    );

    always #20 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_gnt_id"}, 32'(gnt_id), 0);
        check({tag, "_start"}, 32'(start), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_timeout"}, 32'(timeout), 0);
    endtask

    // Waits for start, pops the expected winner, checks the grant and the one-cycle start pulse.
    task automatic take_grant(output int id, output int waited);
        bit got;
        got    = 1'b0;
        waited = 0;
        while (!got && waited < 40) begin
            @(negedge clock);
            waited++;
            got = start;
        end
        check("start_seen", 32'(got), 1);
        id = (exp_q.size() > 0) ? exp_q.pop_front() : 7;
        check("gnt_id", 32'(gnt_id), 32'(id));
        check("gnt_onehot", 32'(gnt), 32'(1) << id);
        check("busy_in_start", 32'(busy), 1);
        @(negedge clock);
        check("start_one_cycle", 32'(start), 0);
        check("busy_in_busy", 32'(busy), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 10) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_gnt_id"}, 32'(gnt_id), 0);
    endtask

    // Pulses done after done_dly cycles in BUSY, checks RELEASE holds gnt, then drops the request.
    task automatic finish_txn(input int id, input int done_dly, input bit drop_all, input bit reraise);
        repeat (done_dly) @(negedge clock);
        done = 1'b1;
        @(negedge clock);
        done = 1'b0;
        check("rel_busy", 32'(busy), 1);
        check("rel_gnt", 32'(gnt), 32'(1) << id);
        check("rel_no_timeout", 32'(timeout), 0);
        repeat (2) @(negedge clock);
        check("rel_hold_gnt", 32'(gnt), 32'(1) << id);
        if (drop_all) req = '0;
        else req[2'(id)] = 1'b0;
        wait_idle("release");
        if (reraise) req[2'(id)] = 1'b1;
    endtask

    initial begin
        int id;
        int waited;
        int tcyc;
        int npulse;

        // Reset state
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        // Single request with latency check; ptr moves to 3
        req = 4'b0100;
        exp_q.push_back(2);
        @(negedge clock);
        check("lat_k", 32'(gnt), 0);
        @(negedge clock);
        check("lat_k1", 32'(gnt), 0);
        take_grant(id, waited);
        check("latency", 32'(waited), 1);
        finish_txn(id, 4, 1'b0, 1'b0);

        // ptr=3 so requester 3 wins over 0, then 0 follows
        req = 4'b1001;
        exp_q.push_back(3);
        exp_q.push_back(0);
        take_grant(id, waited);
        finish_txn(id, 2, 1'b0, 1'b0);
        take_grant(id, waited);
        finish_txn(id, 2, 1'b0, 1'b0);

        // done while idle has no effect
        done = 1'b1;
        repeat (3) @(negedge clock);
        done = 1'b0;
        check("done_idle_busy", 32'(busy), 0);
        check("done_idle_start", 32'(start), 0);

        // Reset brings ptr back to 0
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Contention: all requesters, each re-raised after release
        req = 4'b1111;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        for (int i = 0; i < 5; i++) begin
            take_grant(id, waited);
            finish_txn(id, 1, i == 4, i != 4);
        end

        // Timeout: done never asserted
        req = 4'b0001;
        exp_q.push_back(0);
        take_grant(id, waited);
        tcyc   = -1;
        npulse = 0;
        for (int c = 1; c <= int'(TMO) + 4; c++) begin
            @(negedge clock);
            if (timeout) begin
                npulse++;
                if (tcyc < 0) tcyc = c;
            end
        end
        check("timeout_cycle", 32'(tcyc), 32'(TMO));
        check("timeout_pulses", 32'(npulse), 1);
        check("timeout_busy", 32'(busy), 1);
        check("timeout_gnt_held", 32'(gnt), 32'h1);
        req = '0;
        wait_idle("timeout_release");

        // done on the TMO cycle wins over the timeout
        req = 4'b0010;
        exp_q.push_back(1);
        take_grant(id, waited);
        finish_txn(id, int'(TMO) - 1, 1'b0, 1'b0);

        // Glitches shorter than the clock period, away from edges
        for (int k = 0; k < 8; k++) begin
            @(posedge clock);
            #10;
            req = 4'($urandom_range(1, 15));
            #($urandom_range(2, 3));
            req = '0;
            @(negedge clock);
            check("glitch_gnt", 32'(gnt), 0);
            check("glitch_start", 32'(start), 0);
        end
        repeat (3) @(negedge clock);
        check_all_zero("glitch_after");

        // Reset in the middle of BUSY
        req = 4'b0010;
        exp_q.push_back(1);
        take_grant(id, waited);
        @(negedge clock);
        #5 reset = 1'b1;
        #1 check_all_zero("async_reset");
        #9 reset = 1'b0;
        exp_q.push_back(1);
        take_grant(id, waited);
        check("regrant_latency", 32'(waited), 3);
        finish_txn(id, 3, 1'b0, 1'b0);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
